tune_sequencer: RTL and testbench

Parametrised successor to the free-running single-melody beeper. Plays one of several tunes (background melody, eat jingle, game-over) stored in an external synchronous ROM. Each ROM entry carries its own half-period, duration and end marker, so one instance serves every game sound effect. Sits between the game controller (start/stop/mute) and the piezo output pin, and adds rests, looping, preemption and a done handshake.

---
 rtl/tune_sequencer.sv | 164 ++++++++++++++++
 tb/tb_tune_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tune_sequencer.sv
// Tune sequencer: plays ROM-described tunes (tone/rest notes with durations)
// on a piezo pin, with looping, preemption, stop, mute and a done pulse.
module tune_sequencer #(
  parameter int HP_W        = 17,
  parameter int DUR_W       = 4,
  parameter int UNIT_CYCLES = 10000000,
  parameter int AW          = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [AW-1:0]             tune_base,
  input  logic                      loop,
  input  logic                      stop,
  input  logic                      mute,
  output logic [AW-1:0]             rom_addr,
  input  logic [DUR_W+HP_W:0]       rom_data,
  output logic                      busy,
  output logic                      done,
  output logic                      beep
);

  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  state_t               state;
  logic [AW-1:0]        base_r;
  logic [HP_W-1:0]      hp;
  logic [DUR_W-1:0]     dur;
  logic                 last;
  logic [HP_W-1:0]      tone_cnt;
  logic [UW-1:0]        unit_cnt;
  logic [DUR_W-1:0]     dur_cnt;
  logic                 beep_int;

  logic                 rom_last;
  logic [DUR_W-1:0]     rom_dur;
  logic [HP_W-1:0]      rom_hp;
  logic                 tone_wrap;
  logic                 unit_wrap;
  logic                 note_end;

  assign rom_last = rom_data[DUR_W+HP_W];
  assign rom_dur  = rom_data[HP_W +: DUR_W];
  assign rom_hp   = rom_data[HP_W-1:0];

  // Decode the half-period wrap, duration-unit wrap and last cycle of a note
  always_comb begin
    tone_wrap = 1'b0;
    unit_wrap = 1'b0;
    note_end  = 1'b0;
    tone_wrap = (hp != '0) && (tone_cnt == hp - HP_W'(1));
    unit_wrap = (unit_cnt == UNIT_LAST);
    note_end  = unit_wrap && (dur_cnt == dur - DUR_W'(1));
  end

  // Sequencer FSM with all outputs registered; stop beats start, start preempts
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base_r   <= '0;
      rom_addr <= '0;
      hp       <= '0;
      dur      <= '0;
      last     <= 1'b0;
      tone_cnt <= '0;
      unit_cnt <= '0;
      dur_cnt  <= '0;
      beep_int <= 1'b0;
      beep     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && (state != IDLE)) begin
        state    <= IDLE;
        busy     <= 1'b0;
        beep     <= 1'b0;
        beep_int <= 1'b0;
      end else if (start && !stop) begin
        base_r   <= tune_base;
        rom_addr <= tune_base;
        busy     <= 1'b1;
        beep     <= 1'b0;
        beep_int <= 1'b0;
        state    <= FETCH;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          FETCH: begin
            state <= LOAD;
          end
          LOAD: begin
            hp       <= rom_hp;
            dur      <= rom_dur;
            last     <= rom_last;
            tone_cnt <= '0;
            unit_cnt <= '0;
            dur_cnt  <= '0;
            beep     <= 1'b0;
            beep_int <= 1'b0;
            if (rom_dur == '0) begin
              if (loop) begin
                rom_addr <= base_r;
                state    <= FETCH;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              state <= PLAY;
            end
          end
          PLAY: begin
            if (hp != '0) begin
              if (tone_wrap) begin
                tone_cnt <= '0;
                beep_int <= ~beep_int;
                beep     <= ~beep_int & ~mute;
              end else begin
                tone_cnt <= tone_cnt + HP_W'(1);
                beep     <= beep_int & ~mute;
              end
            end else begin
              tone_cnt <= '0;
              beep_int <= 1'b0;
              beep     <= 1'b0;
            end
            if (unit_wrap) begin
              unit_cnt <= '0;
              dur_cnt  <= dur_cnt + DUR_W'(1);
            end else begin
              unit_cnt <= unit_cnt + UW'(1);
            end
            if (note_end) begin
              beep     <= 1'b0;
              beep_int <= 1'b0;
              if (!last) begin
                rom_addr <= rom_addr + AW'(1);
                state    <= FETCH;
              end else if (loop) begin
                rom_addr <= base_r;
                state    <= FETCH;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tune_sequencer.sv
// Directed testbench for tune_sequencer with a small synchronous ROM model.
module tb_tune_sequencer;

  localparam int HP_W = 17;
  localparam int DUR_W = 4;
  localparam int AW = 8;
  localparam int DW = 1 + DUR_W + HP_W;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] tune_base;
  logic          loop;
  logic          stop;
  logic          mute;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          busy;
  logic          done;
  logic          beep;

  logic [DW-1:0] rom [0:255];

  int compared;
  int mismatched;

  tune_sequencer #(
    .HP_W(HP_W),
    .DUR_W(DUR_W),
    .UNIT_CYCLES(4),
    .AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .tune_base(tune_base),
    .loop(loop),
    .stop(stop),
    .mute(mute),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .busy(busy),
    .done(done),
    .beep(beep)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address changes
  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [DW-1:0] mkEntry(input logic l, input logic [DUR_W-1:0] d,
                                            input logic [HP_W-1:0] h);
    return {l, d, h};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge with the given base; returns 1 time unit after that edge
  task automatic applyStimulus(input logic [AW-1:0] base);
    tune_base = base;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 3; i++) stepCycle();
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b1;
    start = 1'b0;
    tune_base = '0;
    loop = 1'b0;
    stop = 1'b0;
    mute = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = mkEntry(1'b0, 4'd2, 17'd3);
    rom[1] = mkEntry(1'b1, 4'd1, 17'd5);
    rom[2] = mkEntry(1'b1, 4'd3, 17'd0);
    rom[5] = mkEntry(1'b0, 4'd0, 17'd0);

    stepCycle();
    stepCycle();
    checkOutput("rst_beep", 32'(beep), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;
    stepCycle();

    // Two-note tune, unmuted then muted; done must land on the same cycle
    for (int m = 0; m < 2; m++) begin
      mute = (m == 1);
      applyStimulus(8'd0);
      for (int k = 0; k < 18; k++) begin
        if (k > 0) stepCycle();
        checkOutput($sformatf("t1m%0d_beep_k%0d", m, k), 32'(beep),
                    32'((m == 0) && (k >= 5) && (k <= 7)));
        checkOutput($sformatf("t1m%0d_busy_k%0d", m, k), 32'(busy), 32'(k < 16));
        checkOutput($sformatf("t1m%0d_done_k%0d", m, k), 32'(done), 32'(k == 16));
        checkOutput($sformatf("t1m%0d_addr_k%0d", m, k), 32'(rom_addr), (k < 10) ? 32'd0 : 32'd1);
      end
      settle();
    end
    mute = 1'b0;

    // Rest note: silent for 12 PLAY cycles then done
    applyStimulus(8'd2);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) stepCycle();
      checkOutput($sformatf("rest_beep_k%0d", k), 32'(beep), 32'd0);
      checkOutput($sformatf("rest_busy_k%0d", k), 32'(busy), 32'(k < 14));
      checkOutput($sformatf("rest_done_k%0d", k), 32'(done), 32'(k == 14));
    end
    settle();

    // Looping: wrap back to base without done, then finish after loop drops
    loop = 1'b1;
    applyStimulus(8'd0);
    for (int k = 0; k < 34; k++) begin
      if (k > 0) stepCycle();
      if (k == 16) begin
        checkOutput("loop_addr_wrap", 32'(rom_addr), 32'd0);
        loop = 1'b0;
      end
      checkOutput($sformatf("loop_done_k%0d", k), 32'(done), 32'(k == 32));
      checkOutput($sformatf("loop_busy_k%0d", k), 32'(busy), 32'(k < 32));
    end
    settle();

    // Preempt mid-PLAY, then stop+start together
    applyStimulus(8'd0);
    for (int k = 1; k <= 6; k++) stepCycle();
    checkOutput("pre_beep_before", 32'(beep), 32'd1);
    applyStimulus(8'd2);
    checkOutput("pre_addr", 32'(rom_addr), 32'd2);
    checkOutput("pre_beep", 32'(beep), 32'd0);
    checkOutput("pre_done", 32'(done), 32'd0);
    checkOutput("pre_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    applyStimulus(8'd0);
    stop = 1'b0;
    checkOutput("stop_busy", 32'(busy), 32'd0);
    checkOutput("stop_beep", 32'(beep), 32'd0);
    checkOutput("stop_done", 32'(done), 32'd0);
    for (int k = 0; k < 20; k++) begin
      stepCycle();
      checkOutput($sformatf("stop_idle_k%0d", k), 32'({busy, done, beep}), 32'd0);
    end

    // Terminator entry: done two edges after the start edge
    applyStimulus(8'd5);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) stepCycle();
      checkOutput($sformatf("term_done_k%0d", k), 32'(done), 32'(k == 2));
      checkOutput($sformatf("term_busy_k%0d", k), 32'(busy), 32'(k < 2));
    end
    settle();

    // Reset mid-note clears everything on the next cycle
    applyStimulus(8'd0);
    for (int k = 1; k <= 6; k++) stepCycle();
    checkOutput("mid_beep_before", 32'(beep), 32'd1);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("mid_rst_beep", 32'(beep), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    checkOutput("mid_rst_addr", 32'(rom_addr), 32'd0);
    for (int k = 0; k < 20; k++) begin
      stepCycle();
      checkOutput($sformatf("post_rst_k%0d", k), 32'({busy, done, beep}), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
